// File: rtl/team_06_sram_pkg.sv
// Shared types and constants for the team_06 audio-sample SRAM responder.
package team_06_sram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        DONE
    } sram_resp_state_t;

    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h3300_0000;
    localparam logic [3:0]  SEL_ALL           = 4'b1111;

endpackage

// File: rtl/team_06_sram_responder_if.sv
// Initiator <-> responder bus for the team_06 audio-sample SRAM.
interface team_06_sram_responder_if;

    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [3:0]  sel_i;
    logic        write_i;
    logic        read_i;
    logic [31:0] rdata_o;
    logic        busy_o;
    logic        err_o;

    modport master (
        output addr_i, wdata_i, sel_i, write_i, read_i,
        input  rdata_o, busy_o, err_o
    );

    modport slave (
        input  addr_i, wdata_i, sel_i, write_i, read_i,
        output rdata_o, busy_o, err_o
    );

endinterface

// File: rtl/team_06_sram_bank.sv
// DEPTH x 32 word array with byte-masked synchronous write and registered read.
module team_06_sram_bank
    import team_06_sram_pkg::*;
#(
    parameter int unsigned DEPTH = 2048,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] idx_i,
    input  logic             we_i,
    input  logic [3:0]       be_i,
    input  logic [31:0]      wdata_i,
    input  logic             re_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // Byte-masked write; read data holds until the next read enable.
    always_ff @(posedge clk) begin
        if (we_i) begin
            if (be_i == SEL_ALL) begin
                mem_q[idx_i] <= wdata_i;
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (be_i[b]) begin
                        mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/team_06_sram_responder.sv
// Target end of the team_06 audio-sample SRAM bus: window decode, one pending read slot,
// programmable wait states and completion signalled by the falling edge of busy_o.
module team_06_sram_responder
    import team_06_sram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
    parameter int unsigned DEPTH       = 2048,
    parameter int unsigned WAIT_STATES = 2
) (
    input logic                     clk,
    input logic                     rst,
    team_06_sram_responder_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    sram_resp_state_t state_q, state_d;
    logic             write_q, write_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             op_write_q, op_write_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       sel_q, sel_d;
    logic             pend_valid_q, pend_valid_d;
    logic [31:0]      pend_addr_q, pend_addr_d;
    logic             drop_q, drop_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        wr_req, rd_req, drop_now;
    logic [31:0] idx;
    logic        in_range;
    logic        bank_we, bank_re;
    logic [31:0] bank_rdata;

    assign wr_req   = bus.write_i & ~write_q;
    assign rd_req   = bus.read_i;
    // Unsigned subtract: addresses below BASE_ADDR wrap high and fall out of range.
    assign idx      = addr_q - BASE_ADDR;
    assign in_range = idx < 32'(DEPTH);
    assign bank_we  = (state_q == ACCESS) && op_write_q && in_range;
    assign bank_re  = (state_q == ACCESS) && !op_write_q && in_range;

    team_06_sram_bank #(
        .DEPTH (DEPTH)
    ) u_bank (
        .clk     (clk),
        .idx_i   (idx[IDX_W-1:0]),
        .we_i    (bank_we),
        .be_i    (sel_q),
        .wdata_i (wdata_q),
        .re_i    (bank_re),
        .rdata_o (bank_rdata)
    );

    // Request acceptance, pending slot, FSM sequencing and completion outputs.
    always_comb begin
        state_d      = state_q;
        write_d      = bus.write_i;
        busy_d       = busy_q;
        err_d        = err_q;
        rdata_d      = rdata_q;
        op_write_d   = op_write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        sel_d        = sel_q;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        fault_d      = fault_q;
        cnt_d        = cnt_q;
        drop_now     = 1'b0;

        if (state_q == IDLE) begin
            if (pend_valid_q || wr_req || rd_req) begin
                state_d = ACCESS;
                busy_d  = 1'b1;
                err_d   = 1'b0;
            end
            if (pend_valid_q) begin
                // Queued read goes first; a new read refills the slot it vacates.
                op_write_d   = 1'b0;
                addr_d       = pend_addr_q;
                pend_valid_d = rd_req;
                if (rd_req) begin
                    pend_addr_d = bus.addr_i;
                end
                drop_now = wr_req;
            end else if (wr_req) begin
                op_write_d = 1'b1;
                addr_d     = bus.addr_i;
                wdata_d    = bus.wdata_i;
                sel_d      = bus.sel_i;
                if (rd_req) begin
                    pend_valid_d = 1'b1;
                    pend_addr_d  = bus.addr_i;
                end
            end else if (rd_req) begin
                op_write_d = 1'b0;
                addr_d     = bus.addr_i;
            end
        end else begin
            // Busy: one read can wait in the slot; anything else is dropped and flagged.
            if (rd_req) begin
                if (pend_valid_q) begin
                    drop_now = 1'b1;
                end else begin
                    pend_valid_d = 1'b1;
                    pend_addr_d  = bus.addr_i;
                end
            end
            if (wr_req) begin
                drop_now = 1'b1;
            end
        end

        drop_d = drop_q | drop_now;

        case (state_q)
            IDLE: ;
            ACCESS: begin
                fault_d = ~in_range;
                if (WAIT_STATES == 0) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = CNT_W'(WAIT_STATES);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                err_d   = fault_q | drop_q | drop_now;
                drop_d  = 1'b0;
                state_d = IDLE;
                if (!op_write_q) begin
                    rdata_d = fault_q ? 32'h0 : bank_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs, asynchronously cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= 32'h0;
            op_write_q   <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            sel_q        <= 4'h0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= 32'h0;
            drop_q       <= 1'b0;
            fault_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
            op_write_q   <= op_write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            sel_q        <= sel_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            drop_q       <= drop_d;
            fault_q      <= fault_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.rdata_o = rdata_q;
    assign bus.busy_o  = busy_q;
    assign bus.err_o   = err_q;

endmodule

// File: tb/tb_team_06_sram_responder.sv
// Scoreboard bench for team_06_sram_responder: main instance with the default 2 wait states,
// second instance with 4 wait states for the mid-access reset case.
module tb_team_06_sram_responder;

    localparam int unsigned WS  = 2;
    localparam int unsigned WS4 = 4;

    logic clk = 1'b0;
    logic rst;
    logic rst4;

    always #5 clk = ~clk;

    team_06_sram_responder_if bus ();
    team_06_sram_responder_if bus4 ();

    team_06_sram_responder #(
        .WAIT_STATES (WS)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    team_06_sram_responder #(
        .WAIT_STATES (WS4)
    ) u_dut4 (
        .clk (clk),
        .rst (rst4),
        .bus (bus4)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic exp_t ex(input logic [31:0] r, input logic e);
        return '{rdata: r, err: e};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, act, req);
        end
    endtask

    // Monitor: every busy_o falling edge is a completion and must match the oldest expectation.
    logic busy_prev = 1'b0;
    int   busy_len  = 0;
    always @(negedge clk) begin
        exp_t e;
        if (bus.busy_o) begin
            busy_len++;
        end else if (busy_prev) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL completion: got unexpected completion, expected none");
            end else begin
                e = sb_q.pop_front();
                check("rdata", bus.rdata_o, e.rdata);
                check("err", 32'(bus.err_o), 32'(e.err));
                check("busy_len", 32'(busy_len), 32'(2 + WS));
            end
            busy_len = 0;
        end
        busy_prev = bus.busy_o;
    end

    task automatic wait_idle();
        int i = 0;
        while ((sb_q.size() != 0 || bus.busy_o) && i < 300) begin
            @(posedge clk);
            #1;
            i++;
        end
        check("drain", 32'(sb_q.size()), 32'd0);
        // Quiet cycles let any spurious extra completion reach the monitor.
        repeat (8) @(posedge clk);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input exp_t e);
        @(posedge clk);
        #1;
        bus.addr_i  = a;
        bus.wdata_i = d;
        bus.sel_i   = s;
        bus.write_i = 1'b1;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        bus.write_i = 1'b0;
        wait_idle();
    endtask

    task automatic do_read(input logic [31:0] a, input exp_t e);
        @(posedge clk);
        #1;
        bus.addr_i = a;
        bus.read_i = 1'b1;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        bus.read_i = 1'b0;
        wait_idle();
    endtask

    // Single access on the 4-wait-state instance; returns busy-high cycle count.
    task automatic run4(input logic [31:0] a, input logic wr, input logic [31:0] d,
                        output int lat);
        @(posedge clk);
        #1;
        bus4.addr_i  = a;
        bus4.wdata_i = d;
        bus4.sel_i   = 4'hF;
        bus4.write_i = wr;
        bus4.read_i  = ~wr;
        @(posedge clk);
        #1;
        bus4.write_i = 1'b0;
        bus4.read_i  = 1'b0;
        lat = 0;
        while (bus4.busy_o && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int busy_seen;

        bus.addr_i   = '0;
        bus.wdata_i  = '0;
        bus.sel_i    = '0;
        bus.write_i  = 1'b0;
        bus.read_i   = 1'b0;
        bus4.addr_i  = '0;
        bus4.wdata_i = '0;
        bus4.sel_i   = '0;
        bus4.write_i = 1'b0;
        bus4.read_i  = 1'b0;
        rst  = 1'b1;
        rst4 = 1'b1;
        repeat (3) @(negedge clk);
        check("reset rdata", bus.rdata_o, 32'h0);
        check("reset busy", 32'(bus.busy_o), 32'd0);
        check("reset err", 32'(bus.err_o), 32'd0);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        rst4 = 1'b0;

        // 1: full-word write then read back
        do_write(32'h3300_0010, 32'hDEAD_BEEF, 4'b1111, ex(32'h0, 1'b0));
        do_read(32'h3300_0010, ex(32'hDEAD_BEEF, 1'b0));

        // 2: byte-masked overwrite; sel=0 write changes nothing
        do_write(32'h3300_0004, 32'h1122_3344, 4'b1111, ex(32'hDEAD_BEEF, 1'b0));
        do_write(32'h3300_0004, 32'hAABB_CCDD, 4'b0101, ex(32'hDEAD_BEEF, 1'b0));
        do_read(32'h3300_0004, ex(32'h11BB_33DD, 1'b0));
        do_write(32'h3300_0004, 32'hFFFF_FFFF, 4'b0000, ex(32'h11BB_33DD, 1'b0));
        do_read(32'h3300_0004, ex(32'h11BB_33DD, 1'b0));

        // 3: window edges; out-of-range reads return 0 with err, writes leave bank alone
        do_write(32'h3300_0000, 32'h0102_0304, 4'b1111, ex(32'h11BB_33DD, 1'b0));
        do_write(32'h3300_07FF, 32'hCAFE_F00D, 4'b1111, ex(32'h11BB_33DD, 1'b0));
        do_read(32'h3300_0800, ex(32'h0, 1'b1));
        do_read(32'h32FF_FFFC, ex(32'h0, 1'b1));
        do_write(32'h3300_0800, 32'hFFFF_FFFF, 4'b1111, ex(32'h0, 1'b1));
        do_read(32'h3300_0000, ex(32'h0102_0304, 1'b0));
        do_read(32'h3300_07FF, ex(32'hCAFE_F00D, 1'b0));

        // 4: write edge and read pulse together -> write, then queued read
        @(posedge clk);
        #1;
        bus.addr_i  = 32'h3300_0003;
        bus.wdata_i = 32'h0000_0005;
        bus.sel_i   = 4'b1111;
        bus.write_i = 1'b1;
        bus.read_i  = 1'b1;
        sb_q.push_back(ex(32'hCAFE_F00D, 1'b0));
        sb_q.push_back(ex(32'h0000_0005, 1'b0));
        @(posedge clk);
        #1;
        bus.write_i = 1'b0;
        bus.read_i  = 1'b0;
        wait_idle();

        // 5a: write_i held high for 10 cycles performs exactly one write
        @(posedge clk);
        #1;
        bus.addr_i  = 32'h3300_0005;
        bus.wdata_i = 32'h0000_0077;
        bus.write_i = 1'b1;
        sb_q.push_back(ex(32'h0000_0005, 1'b0));
        repeat (10) @(posedge clk);
        #1;
        bus.write_i = 1'b0;
        wait_idle();

        // 5b: read, queued read, then a third read with the slot full is dropped
        @(posedge clk);
        #1;
        bus.addr_i = 32'h3300_0003;
        bus.read_i = 1'b1;
        sb_q.push_back(ex(32'h0000_0005, 1'b1));
        @(posedge clk);
        #1;
        bus.addr_i = 32'h3300_0005;
        sb_q.push_back(ex(32'h0000_0077, 1'b0));
        @(posedge clk);
        #1;
        bus.addr_i = 32'h3300_0010;
        @(posedge clk);
        #1;
        bus.read_i = 1'b0;
        wait_idle();

        // 5c: write edge during a read is dropped and flagged; target stays intact
        @(posedge clk);
        #1;
        bus.addr_i = 32'h3300_0010;
        bus.read_i = 1'b1;
        sb_q.push_back(ex(32'hDEAD_BEEF, 1'b1));
        @(posedge clk);
        #1;
        bus.read_i  = 1'b0;
        bus.wdata_i = 32'h0;
        bus.sel_i   = 4'b1111;
        bus.write_i = 1'b1;
        @(posedge clk);
        #1;
        bus.write_i = 1'b0;
        wait_idle();
        do_read(32'h3300_0010, ex(32'hDEAD_BEEF, 1'b0));

        // 6: reset during WAIT on the 4-wait-state instance
        run4(32'h3300_0001, 1'b1, 32'h0000_CAFE, lat);
        check("ws4 write latency", 32'(lat), 32'(2 + WS4));
        run4(32'h3300_0001, 1'b0, 32'h0, lat);
        check("ws4 read latency", 32'(lat), 32'(2 + WS4));
        check("ws4 read data", bus4.rdata_o, 32'h0000_CAFE);
        @(posedge clk);
        #1;
        bus4.addr_i = 32'h3300_0001;
        bus4.read_i = 1'b1;
        @(posedge clk);
        #1;
        bus4.addr_i = 32'h3300_0002;
        @(posedge clk);
        #1;
        bus4.read_i = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst4 = 1'b1;
        #1;
        check("ws4 rst busy", 32'(bus4.busy_o), 32'd0);
        check("ws4 rst rdata", bus4.rdata_o, 32'h0);
        check("ws4 rst err", 32'(bus4.err_o), 32'd0);
        @(posedge clk);
        #1;
        rst4 = 1'b0;
        busy_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus4.busy_o) busy_seen++;
        end
        check("ws4 pending cleared", 32'(busy_seen), 32'd0);
        run4(32'h3300_0001, 1'b0, 32'h0, lat);
        check("ws4 post-reset latency", 32'(lat), 32'(2 + WS4));
        check("ws4 post-reset err", 32'(bus4.err_o), 32'd0);
        run4(32'h3300_0002, 1'b1, 32'h0000_1234, lat);
        run4(32'h3300_0002, 1'b0, 32'h0, lat);
        check("ws4 post-reset data", bus4.rdata_o, 32'h0000_1234);

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
